// File: rtl/sine_nco_pkg.sv
// Shared constants and types for the quarter-wave sine NCO.
// The PHASE_DITHER_EN macro selects LFSR phase dithering in nco_phase_accum.
package sine_nco_pkg;

  localparam int unsigned ROM_ADDR_W = 14;
  localparam int unsigned ROM_DATA_W = 16;
  localparam int unsigned PHASE_W    = 16;
  localparam int unsigned OUT_W      = 17;

  // Quadrant codes taken from the top two phase bits
  localparam logic [1:0] Q0 = 2'b00;
  localparam logic [1:0] Q1 = 2'b01;
  localparam logic [1:0] Q2 = 2'b10;
  localparam logic [1:0] Q3 = 2'b11;

  // 15-bit Fibonacci LFSR, polynomial x^15 + x^14 + 1
  localparam int unsigned LFSR_W    = 15;
  localparam logic [14:0] LFSR_SEED = 15'h0001;
  localparam logic [14:0] LFSR_TAPS = 15'h6000;

  typedef struct packed {
    logic [1:0]            quad;
    logic [ROM_ADDR_W-1:0] idx;
  } phase_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/nco_phase_accum.sv
// Phase accumulator: FCW register, accumulator with sync clear, phase offset add
// and optional LFSR dither (enabled by defining PHASE_DITHER_EN).
module nco_phase_accum
  import sine_nco_pkg::*;
#(
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned DITH_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [ACC_W-1:0]   i_fcw,
  input  logic               i_fcw_load,
  input  logic [PHASE_W-1:0] i_phase_off,
  input  logic               i_en,
  input  logic               i_sync,
  output logic [PHASE_W-1:0] o_phase,
  output logic               o_valid
);

  localparam int unsigned ExtW = PHASE_W + DITH_W;

  logic [ACC_W-1:0]   fcw_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_base;
  logic [ACC_W-1:0]   acc_d;
  logic [DITH_W-1:0]  dith;
  logic [PHASE_W-1:0] phase_d;

`ifdef PHASE_DITHER_EN
  logic [LFSR_W-1:0] lfsr_q;

  // LFSR advances once per accepted sample; sync leaves it running
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else if (i_en) begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  assign dith = lfsr_q[DITH_W-1:0];
`else
  // Zero dither keeps the datapath a plain truncation
  assign dith = '0;
`endif

  // Sync forces the sample to see a cleared accumulator
  assign acc_base = i_sync ? '0 : acc_q;

  // Next accumulator value and sample phase (dither carry may ripple into the phase)
  always_comb begin
    acc_d = acc_q;
    if (i_sync) acc_d = '0;
    if (i_en)   acc_d = acc_base + fcw_q;
    phase_d = PHASE_W'((acc_base[ACC_W-1 -: ExtW] + ExtW'(dith)) >> DITH_W) + i_phase_off;
  end

  // FCW, accumulator and registered phase/valid
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fcw_q   <= '0;
      acc_q   <= '0;
      o_phase <= '0;
      o_valid <= 1'b0;
    end else begin
      if (i_fcw_load) fcw_q <= i_fcw;
      acc_q   <= acc_d;
      o_valid <= i_en;
      if (i_en) o_phase <= phase_d;
    end
  end

endmodule

// File: rtl/sine_nco_ctrl.sv
// Full-wave NCO around a quarter-wave sine ROM: quadrant fold to the ROM
// address, quadrant/valid delay matching the ROM latency, sign restore.
// Define PHASE_DITHER_EN to enable LFSR phase dithering.
module sine_nco_ctrl
  import sine_nco_pkg::*;
#(
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned ROM_LAT = 1,
  parameter int unsigned DITH_W  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ACC_W-1:0]      i_fcw,
  input  logic                  i_fcw_load,
  input  logic [PHASE_W-1:0]    i_phase_off,
  input  logic                  i_en,
  input  logic                  i_sync,
  output logic [ROM_ADDR_W-1:0] o_rom_addr,
  input  logic [ROM_DATA_W-1:0] i_rom_data,
  output logic [OUT_W-1:0]      o_data,
  output logic                  o_valid
);

  logic [PHASE_W-1:0]    phase;
  logic                  phase_vld;
  phase_t                ph;
  logic [ROM_ADDR_W-1:0] addr_fold;

  logic [1:0]                quad_a_q;
  logic                      vld_a_q;
  logic [ROM_LAT-1:0][1:0]   quad_dly_q;
  logic [ROM_LAT-1:0]        vld_dly_q;
  logic [1:0]                quad_b;
  logic                      vld_b;
  logic [OUT_W-1:0]          mag_ext;
  logic [OUT_W-1:0]          sample;

  nco_phase_accum #(
    .ACC_W  (ACC_W),
    .DITH_W (DITH_W)
  ) u_accum (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_fcw       (i_fcw),
    .i_fcw_load  (i_fcw_load),
    .i_phase_off (i_phase_off),
    .i_en        (i_en),
    .i_sync      (i_sync),
    .o_phase     (phase),
    .o_valid     (phase_vld)
  );

  assign ph = phase_t'(phase);

  // Odd quadrants walk the quarter table backwards
  always_comb begin
    addr_fold = ph.idx;
    unique case (ph.quad)
      Q0, Q2: addr_fold = ph.idx;
      Q1, Q3: addr_fold = ~ph.idx;
    endcase
  end

  // Stage A address register plus quadrant/valid delay covering the ROM read
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rom_addr <= '0;
      quad_a_q   <= Q0;
      vld_a_q    <= 1'b0;
      quad_dly_q <= '0;
      vld_dly_q  <= '0;
    end else begin
      if (phase_vld) begin
        o_rom_addr <= addr_fold;
        quad_a_q   <= ph.quad;
      end
      vld_a_q       <= phase_vld;
      quad_dly_q[0] <= quad_a_q;
      vld_dly_q[0]  <= vld_a_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        quad_dly_q[i] <= quad_dly_q[i-1];
        vld_dly_q[i]  <= vld_dly_q[i-1];
      end
    end
  end

  assign quad_b  = quad_dly_q[ROM_LAT-1];
  assign vld_b   = vld_dly_q[ROM_LAT-1];
  assign mag_ext = {1'b0, i_rom_data};

  // Lower half-wave is negated; a zero magnitude stays zero
  assign sample = (quad_b == Q2 || quad_b == Q3) ? -mag_ext : mag_ext;

  // Stage B output register, holds the last sample between strobes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= vld_b;
      if (vld_b) o_data <= sample;
    end
  end

endmodule

// File: tb/tb_sine_nco_ctrl.sv
// Self-checking bench for sine_nco_ctrl with a 1-cycle ROM returning {2'b00, addr}.
module tb_sine_nco_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_fcw = '0;
  logic        i_fcw_load = 1'b0;
  logic [15:0] i_phase_off = '0;
  logic        i_en = 1'b0;
  logic        i_sync = 1'b0;
  logic [13:0] o_rom_addr;
  logic [15:0] i_rom_data = '0;
  logic [16:0] o_data;
  logic        o_valid;

  int unsigned checks = 0;
  int unsigned errors = 0;

  sine_nco_ctrl dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_fcw       (i_fcw),
    .i_fcw_load  (i_fcw_load),
    .i_phase_off (i_phase_off),
    .i_en        (i_en),
    .i_sync      (i_sync),
    .o_rom_addr  (o_rom_addr),
    .i_rom_data  (i_rom_data),
    .o_data      (o_data),
    .o_valid     (o_valid)
  );

  always #5 i_clk = ~i_clk;

  // Quarter-wave ROM model, one cycle read
  always @(posedge i_clk) i_rom_data <= {2'b00, o_rom_addr};

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned due;
    logic [16:0] val;
  } exp_t;

  exp_t            exp_q[$];
  exp_t            addr_q[$];
  logic [16:0]     obs[$];
  longint unsigned m_acc, m_fcw, m_base, m_ph;
  logic [14:0]     m_lfsr;
  int unsigned     cyc = 0;
  logic [16:0]     last_data = '0;
  logic [16:0]     last_addr = '0;

  function automatic longint unsigned model_addr(input longint unsigned ph);
    longint unsigned q = ph / 16384;
    longint unsigned idx = ph % 16384;
    return (q % 2 == 1) ? 16383 - idx : idx;
  endfunction

  function automatic logic [16:0] model_sample(input longint unsigned ph);
    int mag = int'(model_addr(ph));
    int v = (ph / 16384 >= 2) ? -mag : mag;
    return 17'(v);
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_acc = 0;
      m_fcw = 0;
      m_lfsr = 15'h0001;
      exp_q.delete();
      addr_q.delete();
      last_data = '0;
      last_addr = '0;
    end else begin
      cyc++;
      if (i_en) begin
        m_base = i_sync ? 0 : m_acc;
`ifdef PHASE_DITHER_EN
        m_ph = ((((m_base >> 8) + (longint'(m_lfsr) % 256)) >> 8) + i_phase_off) % 65536;
        m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
`else
        m_ph = ((m_base >> 16) + i_phase_off) % 65536;
`endif
        exp_q.push_back('{due: cyc + 3, val: model_sample(m_ph)});
        addr_q.push_back('{due: cyc + 1, val: 17'(model_addr(m_ph))});
        m_acc = (m_base + m_fcw) % 64'h1_0000_0000;
      end else if (i_sync) begin
        m_acc = 0;
      end
      if (i_fcw_load) m_fcw = longint'(i_fcw);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_obs(input string name, input int idx, input logic [16:0] exp);
    if (idx >= obs.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: sample %0d missing, expected %h", name, idx, exp);
    end else begin
      chk(name, 32'(obs[idx]), 32'(exp));
    end
  endtask

  // Per-cycle compare against the model, away from the active edge
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_valid) obs.push_back(o_data);
      if (addr_q.size() > 0 && addr_q[0].due == cyc) begin
        chk("rom_addr", 32'(o_rom_addr), 32'(addr_q[0].val));
        last_addr = addr_q[0].val;
        void'(addr_q.pop_front());
      end else begin
        chk("rom_addr_hold", 32'(o_rom_addr), 32'(last_addr));
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        chk("valid", 32'(o_valid), 32'd1);
        chk("data", 32'(o_data), 32'(exp_q[0].val));
        last_data = exp_q[0].val;
        void'(exp_q.pop_front());
      end else begin
        chk("no_valid", 32'(o_valid), 32'd0);
        chk("data_hold", 32'(o_data), 32'(last_data));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic en, input logic sync, input logic load,
                       input logic [31:0] fcw, input logic [15:0] off);
    @(negedge i_clk);
    i_en = en;
    i_sync = sync;
    i_fcw_load = load;
    i_fcw = fcw;
    i_phase_off = off;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, i_fcw, i_phase_off);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge i_clk);
    chk("rst_addr", 32'(o_rom_addr), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    i_rst_n = 1'b1;
    idle(2);

    // Sweep in 0x1000 phase steps
    obs.delete();
    drive(1'b0, 1'b0, 1'b1, 32'h1000_0000, 16'h0000);
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 1'b0, 32'h1000_0000, 16'h0000);
    idle(6);
    chk("sweep_count", obs.size(), 32'd16);
    chk_obs("sweep_0000", 0, 17'h00000);
    chk_obs("sweep_1000", 1, 17'h01000);
    chk_obs("sweep_5000", 5, 17'h02FFF);
    chk_obs("sweep_9000", 9, 17'h1F000);
    chk_obs("sweep_D000", 13, 17'h1D001);

    // Offset and accumulator wrap
    obs.delete();
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_0000, 16'h4000);
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_0000, 16'h4000);
    drive(1'b1, 1'b0, 1'b0, 32'hFFFF_0000, 16'h4000);
    drive(1'b1, 1'b0, 1'b0, 32'hFFFF_0000, 16'h4000);
    idle(6);
    chk_obs("wrap_4000", 0, 17'h03FFF);
    chk_obs("wrap_3FFF", 1, 17'h03FFF);
    chk_obs("wrap_3FFE", 2, 17'h03FFE);

    // Sync clears the phase mid-stream
    obs.delete();
    drive(1'b0, 1'b0, 1'b1, 32'h0100_0000, 16'h0010);
    drive(1'b0, 1'b1, 1'b0, 32'h0100_0000, 16'h0010);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 32'h0100_0000, 16'h0010);
    drive(1'b1, 1'b1, 1'b0, 32'h0100_0000, 16'h0010);
    drive(1'b1, 1'b0, 1'b0, 32'h0100_0000, 16'h0010);
    idle(6);
    chk_obs("sync_pre", 4, 17'h00410);
    chk_obs("sync_hit", 5, 17'h00010);
    chk_obs("sync_next", 6, 17'h00110);

    // FCW load together with i_en, then gapped strobes
    obs.delete();
    drive(1'b1, 1'b0, 1'b1, 32'h0200_0000, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      idle(2);
      drive(1'b1, 1'b0, 1'b0, 32'h0200_0000, 16'h0000);
    end
    idle(6);
    chk("gap_count", obs.size(), 32'd4);
    chk_obs("load_old", 0, 17'h00200);
    chk_obs("load_new1", 1, 17'h00300);
    chk_obs("load_new3", 3, 17'h00700);

    // Reset in the middle of a stream flushes in-flight samples
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 32'h0200_0000, 16'h0000);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_addr", 32'(o_rom_addr), 32'd0);
    chk("mid_rst_data", 32'(o_data), 32'd0);
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_en = 1'b0;
    obs.delete();
    idle(6);
    chk("flush_no_valid", obs.size(), 32'd0);

    // Zero FCW: dither may never push the phase off zero
    obs.delete();
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0000, 16'h0000);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'b0, 32'h0000_0000, 16'h0000);
    idle(6);
    chk("dith_count", obs.size(), 32'd20);
    for (int i = 0; i < 20; i += 5) chk_obs("dith_zero", i, 17'h00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
